bsg_mem_1r1w_sync_mask_write_byte_scheduler: RTL
================================================

Name: bsg_mem_1r1w_sync_mask_write_byte_scheduler

Overview:
Front-end controller for a 1-read/1-write synchronous byte-masked SRAM.
- Optionally zero-fills the array after reset.
- Accepts writes and reads through ready/valid ports.
- Prevents same-address read/write collisions by deferring the read one cycle, so the write lands first.
- Buffers each synchronous read result behind a valid/yumi handshake so consumers can backpressure.
- Sits between client logic and the memory instance; drives all memory-side signals.

Parameters:
width_p, none (must be set), data width in bits; multiple of 8.
els_p, none (must be set), number of memory entries.
init_zero_p, 1, 1 = zero-fill all entries after reset before accepting traffic; 0 = ready immediately after reset.
addr_width_lp, safe clog2(els_p), address width (derived).
mask_width_lp, width_p>>3, byte-mask width (derived).

Ports:
clk_i  in  1  clock; all logic on rising edge.
reset_i  in  1  synchronous, active-high reset.
w_v_i  in  1  write request valid.
w_mask_i  in  mask_width_lp  byte enables for the write.
w_addr_i  in  addr_width_lp  write address.
w_data_i  in  width_p  write data.
w_ready_o  out  1  write accepted when w_v_i & w_ready_o.
r_v_i  in  1  read request valid.
r_addr_i  in  addr_width_lp  read address.
r_ready_o  out  1  read accepted when r_v_i & r_ready_o.
r_data_v_o  out  1  read data valid.
r_data_o  out  width_p  read data.
r_yumi_i  in  1  consumer takes r_data_o; legal only when r_data_v_o=1.
init_done_o  out  1  high once the controller is in RUN.
mem_w_v_o  out  1  to memory w_v_i.
mem_w_mask_o  out  mask_width_lp  to memory w_mask_i.
mem_w_addr_o  out  addr_width_lp  to memory w_addr_i.
mem_w_data_o  out  width_p  to memory w_data_i.
mem_r_v_o  out  1  to memory r_v_i.
mem_r_addr_o  out  addr_width_lp  to memory r_addr_i.
mem_r_data_i  in  width_p  from memory r_data_o; valid the cycle after mem_r_v_o.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to INIT if init_zero_p=1, else RUN.
  - Init counter cleared; issued_r and held_v_r cleared.
  - During reset, all outputs are 0: w_ready_o, r_ready_o, r_data_v_o, init_done_o, mem_w_v_o, mem_r_v_o.
- INIT state:
  - Each cycle: mem_w_v_o=1, mem_w_addr_o=counter, mem_w_mask_o=all ones, mem_w_data_o=0, mem_r_v_o=0.
  - w_ready_o=r_ready_o=0; client inputs are ignored.
  - Counter increments from 0 to els_p-1. The cycle after the els_p-1 write, state goes to RUN. INIT lasts exactly els_p cycles; the counter never wraps.
- RUN state:
  - init_done_o=1; w_ready_o=1.
  - Writes pass through combinationally: mem_w_v_o=w_v_i, and mask/addr/data are forwarded unchanged. Zero latency; writes are never stalled.
  - A write with mask 0 is still forwarded (mem_w_v_o=1) and is harmless.
- Collision rule:
  - collide = w_v_i & r_v_i & (w_addr_i==r_addr_i).
  - When collide=1, r_ready_o=0 and the read is not issued. On the next cycle it sees the written data.
  - The controller therefore never drives same-address read and write in one cycle.
- Read acceptance:
  - r_ready_o = RUN & ~collide & (~r_data_v_o | r_yumi_i).
  - At most one result is outstanding or held at any time.
  - mem_r_v_o = r_v_i & r_ready_o; mem_r_addr_o = r_addr_i.
- Read return (1-cycle latency):
  - issued_r <= mem_r_v_o.
  - r_data_v_o = issued_r | held_v_r.
  - r_data_o = issued_r ? mem_r_data_i : held_r.
  - If issued_r & ~r_yumi_i: held_r <= mem_r_data_i and held_v_r <= 1.
  - If r_yumi_i: held_v_r <= 0.
  - issued_r and held_v_r are never both 1.
- Simultaneous yumi and new read: both are allowed in the same cycle, giving back-to-back reads at full throughput of 1 per cycle.
- Reset mid-operation:
  - Pending or held read data is discarded; r_data_v_o drops the cycle reset is sampled.
  - INIT restarts from address 0.
- Simulation-only check: r_yumi_i while r_data_v_o=0 triggers $error.

Test Plan:
- els_p=16, width_p=32, init_zero_p=1: release reset → mem_w_v_o=1 for exactly 16 cycles, addresses 0..15, mask 4'hF, data 0; ready signals low; init_done_o=1 on cycle 17. Then read addr 5 → r_data_o=0.
- Byte write: write addr 3 data 32'hAABBCCDD mask 4'b0101, then read addr 3 → r_data_v_o one cycle after accept, r_data_o=32'h00BB00DD.
- Collision: same cycle w_v_i=1 and r_v_i=1 on addr 7, data 32'h12345678, mask 4'hF → r_ready_o=0 that cycle, no mem_r_v_o; read accepted next cycle → returns 32'h12345678.
- Backpressure: issue read of addr 2 (holding 32'h55), hold r_yumi_i=0 for 3 cycles → r_data_v_o stays 1 with r_data_o=32'h55, r_ready_o=0; assert yumi → a new read is accepted that same cycle.
- Streaming: reads of addrs 0..7 with r_yumi_i tied to r_data_v_o → 8 consecutive accepts, then 8 consecutive results in address order.
- Reset mid-INIT at counter=9 and mid-held-data → INIT restarts at addr 0, r_data_v_o=0, full 16-cycle INIT repeats.

Source files
------------

// File: rtl/bsg_mem_1r1w_sync_mask_write_byte_scheduler.sv
// Front-end controller for a 1R1W synchronous byte-masked SRAM: optional zero-fill
// after reset, pass-through writes, collision-deferred reads and a one-entry read buffer.
module bsg_mem_1r1w_sync_mask_write_byte_scheduler #(
    parameter int unsigned width_p       = 32,
    parameter int unsigned els_p         = 16,
    parameter int unsigned init_zero_p   = 1,
    parameter int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int unsigned mask_width_lp = width_p >> 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     w_v_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    output logic                     w_ready_o,

    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic                     r_ready_o,

    output logic                     r_data_v_o,
    output logic [width_p-1:0]       r_data_o,
    input  logic                     r_yumi_i,

    output logic                     init_done_o,

    output logic                     mem_w_v_o,
    output logic [mask_width_lp-1:0] mem_w_mask_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,
    output logic                     mem_r_v_o,
    output logic [addr_width_lp-1:0] mem_r_addr_o,
    input  logic [width_p-1:0]       mem_r_data_i
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e                   ResetState = (init_zero_p != 0) ? ST_INIT : ST_RUN;
    localparam logic [addr_width_lp-1:0] LastAddr   = addr_width_lp'(els_p - 1);

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] cnt_q, cnt_d;
    logic                     issued_q, issued_d;
    logic                     held_v_q, held_v_d;
    logic [width_p-1:0]       held_q, held_d;

    logic in_run, in_init, collide;

    // State register and control flops
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ResetState;
            cnt_q    <= '0;
            issued_q <= 1'b0;
            held_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            held_v_q <= held_v_d;
        end
    end

    // Held read data needs no reset; its valid bit qualifies it
    always_ff @(posedge clk_i) begin
        held_q <= held_d;
    end

    // Next-state: INIT walks every address exactly once, then RUN forever
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LastAddr) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + addr_width_lp'(1);
            end
        end
    end

    // Read-return buffer: capture unconsumed results, release on yumi
    always_comb begin
        issued_d = mem_r_v_o;
        held_v_d = held_v_q;
        held_d   = held_q;
        if (issued_q && !r_yumi_i) begin
            held_d   = mem_r_data_i;
            held_v_d = 1'b1;
        end else if (r_yumi_i) begin
            held_v_d = 1'b0;
        end
    end

    // Outputs: reset gates everything off in the cycle it is sampled
    always_comb begin
        in_run  = (state_q == ST_RUN)  && !reset_i;
        in_init = (state_q == ST_INIT) && !reset_i;
        collide = w_v_i && r_v_i && (w_addr_i == r_addr_i);

        init_done_o  = in_run;
        w_ready_o    = in_run;

        mem_w_v_o    = in_init || (in_run && w_v_i);
        mem_w_addr_o = in_init ? cnt_q : w_addr_i;
        mem_w_mask_o = in_init ? {mask_width_lp{1'b1}} : w_mask_i;
        mem_w_data_o = in_init ? {width_p{1'b0}} : w_data_i;

        r_data_v_o   = !reset_i && (issued_q || held_v_q);
        r_data_o     = issued_q ? mem_r_data_i : held_q;

        // A colliding read waits a cycle so it observes the write
        r_ready_o    = in_run && !collide && (!r_data_v_o || r_yumi_i);
        mem_r_v_o    = r_v_i && r_ready_o;
        mem_r_addr_o = r_addr_i;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && r_yumi_i && !r_data_v_o) begin
            $error("r_yumi_i asserted without r_data_v_o");
        end
    end
`endif

endmodule
